// File: rtl/carrier_mixer_pkg.sv
// rtl/carrier_mixer_pkg.sv - shared constants, sign/magnitude type and helpers for carrier_mixer
package carrier_mixer_pkg;

    localparam logic [1:0] MAG_1 = 2'b00;
    localparam logic [1:0] MAG_2 = 2'b01;
    localparam logic [1:0] MAG_3 = 2'b10;
    localparam logic [1:0] MAG_6 = 2'b11;

    localparam logic SIGN_POS = 1'b1;
    localparam logic SIGN_NEG = 1'b0;

    typedef struct packed {
        logic       sign;
        logic [1:0] mag;
    } sm_sample_t;

    // Sign/magnitude product to 4-bit two's complement, range -6..+6
    function automatic logic [3:0] sm_to_twos(input sm_sample_t s);
        logic [3:0] m;
        case (s.mag)
            MAG_1:   m = 4'd1;
            MAG_2:   m = 4'd2;
            MAG_3:   m = 4'd3;
            default: m = 4'd6;
        endcase
        return (s.sign == SIGN_POS) ? m : (~m + 4'd1);
    endfunction

endpackage

// File: rtl/carrier_mixer_lut.sv
// rtl/carrier_mixer_lut.sv - combinational 2x2-bit sign/magnitude product table
module carrier_mixer_lut
    import carrier_mixer_pkg::*;
(
    input  logic       if_sign,
    input  logic       if_mag,
    input  logic       carrier_sign,
    input  logic       carrier_mag,
    output sm_sample_t prod
);

    always_comb begin
        prod.sign = ~(if_sign ^ carrier_sign);
        prod.mag  = MAG_1;
        // IF magnitude {1,3} times carrier magnitude {1,2}
        case ({if_mag, carrier_mag})
            2'b00:   prod.mag = MAG_1;
            2'b01:   prod.mag = MAG_2;
            2'b10:   prod.mag = MAG_3;
            default: prod.mag = MAG_6;
        endcase
    end

endmodule

// File: rtl/carrier_mixer.sv
// rtl/carrier_mixer.sv - registered carrier wipe-off multiplier; CARRIER_MIXER_TWOS_EN adds mix_value
module carrier_mixer
    import carrier_mixer_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic       sample_en,
    input  logic       if_sign,
    input  logic       if_mag,
    input  logic       carrier_sign,
    input  logic       carrier_mag,
    output logic       mix_sign,
    output logic [1:0] mix_mag,
    output logic       mix_valid
`ifdef CARRIER_MIXER_TWOS_EN
    ,
    output logic [3:0] mix_value
`endif
);

    sm_sample_t prod;

    carrier_mixer_lut u_lut (
        .if_sign      (if_sign),
        .if_mag       (if_mag),
        .carrier_sign (carrier_sign),
        .carrier_mag  (carrier_mag),
        .prod         (prod)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mix_sign  <= SIGN_NEG;
            mix_mag   <= MAG_1;
            mix_valid <= 1'b0;
        end else begin
            mix_valid <= sample_en;
            if (sample_en) begin
                mix_sign <= prod.sign;
                mix_mag  <= prod.mag;
            end
        end
    end

`ifdef CARRIER_MIXER_TWOS_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mix_value <= 4'd0;
        end else if (sample_en) begin
            mix_value <= sm_to_twos(prod);
        end
    end
`endif

endmodule

// File: tb/tb_carrier_mixer.sv
// tb/tb_carrier_mixer.sv - scoreboard bench for carrier_mixer
module tb_carrier_mixer;

    logic       clk = 1'b0;
    logic       rstn;
    logic       sample_en;
    logic       if_sign, if_mag, carrier_sign, carrier_mag;
    logic       mix_sign;
    logic [1:0] mix_mag;
    logic       mix_valid;
`ifdef CARRIER_MIXER_TWOS_EN
    logic [3:0] mix_value;
`endif

    typedef struct {
        logic       valid;
        logic       sign;
        logic [1:0] mag;
        int         value;
    } exp_t;

    exp_t sb_q[$];
    exp_t last;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    carrier_mixer dut (
        .clk          (clk),
        .rstn         (rstn),
        .sample_en    (sample_en),
        .if_sign      (if_sign),
        .if_mag       (if_mag),
        .carrier_sign (carrier_sign),
        .carrier_mag  (carrier_mag),
        .mix_sign     (mix_sign),
        .mix_mag      (mix_mag),
        .mix_valid    (mix_valid)
`ifdef CARRIER_MIXER_TWOS_EN
        ,
        .mix_value    (mix_value)
`endif
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: arithmetic product of the decoded values
    function automatic exp_t model(input logic en, input logic s, input logic m,
                                   input logic cs, input logic cm, input exp_t prev);
        exp_t e;
        int   a, b, p;
        e = prev;
        e.valid = en;
        if (en) begin
            a = (s ? 1 : -1) * (m ? 3 : 1);
            b = (cs ? 1 : -1) * (cm ? 2 : 1);
            p = a * b;
            e.sign  = (p > 0);
            e.value = p;
            case (p < 0 ? -p : p)
                1:       e.mag = 2'b00;
                2:       e.mag = 2'b01;
                3:       e.mag = 2'b10;
                default: e.mag = 2'b11;
            endcase
        end
        return e;
    endfunction

    task automatic compare_outputs(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 0, 1);
            return;
        end
        e = sb_q.pop_front();
        check({tag, "_valid"}, int'(mix_valid), int'(e.valid));
        check({tag, "_sign"},  int'(mix_sign),  int'(e.sign));
        check({tag, "_mag"},   int'(mix_mag),   int'(e.mag));
`ifdef CARRIER_MIXER_TWOS_EN
        check({tag, "_value"}, int'($signed(mix_value)), e.value);
`endif
    endtask

    // Called at a negedge: drive, let one posedge pass, compare at the next negedge
    task automatic step(input string tag, input logic en, input logic s, input logic m,
                        input logic cs, input logic cm);
        sample_en = en; if_sign = s; if_mag = m; carrier_sign = cs; carrier_mag = cm;
        last = model(en, s, m, cs, cm, last);
        sb_q.push_back(last);
        @(negedge clk);
        compare_outputs(tag);
    endtask

    task automatic reset_model();
        last.valid = 1'b0; last.sign = 1'b0; last.mag = 2'b00; last.value = 0;
        sb_q.delete();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"}, int'(mix_valid), 0);
        check({tag, "_sign"},  int'(mix_sign),  0);
        check({tag, "_mag"},   int'(mix_mag),   0);
`ifdef CARRIER_MIXER_TWOS_EN
        check({tag, "_value"}, int'(mix_value), 0);
`endif
    endtask

    initial begin
        rstn = 1'b0; sample_en = 1'b0;
        if_sign = 1'b0; if_mag = 1'b0; carrier_sign = 1'b0; carrier_mag = 1'b0;
        reset_model();
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rstn = 1'b1;

        // Idle cycle after reset: no capture
        step("idle", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);

        // Exhaustive sweep of all 16 combinations
        for (int i = 0; i < 16; i++) begin
            logic [3:0] v;
            v = 4'(i);
            step("sweep", 1'b1, v[3], v[2], v[1], v[0]);
        end

        // Capture +6, then hold with toggling inputs
        step("cap_p6", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++)
            step("hold", 1'b0, 1'(i), ~1'(i), 1'(i), ~1'(i));

        // Capture -6, then asynchronous reset between edges
        step("cap_n6", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        #2 rstn = 1'b0;
        #1 check_reset_state("async_rst");
        reset_model();
        sample_en = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        step("post_rst", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

        // Continuous random stream
        for (int i = 0; i < 1000; i++) begin
            logic [3:0] r;
            r = 4'($urandom_range(0, 15));
            step("rand", 1'b1, r[3], r[2], r[1], r[0]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
